as_sc_ro_freq_counter: RTL and testbench
========================================

Name: as_sc_ro_freq_counter

Overview:
Measurement end of the standard-cell ring-oscillator characterization path. It enables a ring oscillator built from library inverter and buffer cells, then waits a settle period. It counts rising edges of the oscillator output (pre-divided so it is below CLK/2) over a programmable gate of CLK cycles and holds the result for readout. It sits in the test-chip harness between the cell-under-test rings and the host register interface.

Parameters:
CW, 16, width of COUNT and the edge counter
GW, 16, width of GATE_LEN
SETTLE, 8, CLK cycles RO_EN is high before counting starts (minimum 1)

Ports:
CLK  input  1  sole clock; all state updates on posedge
RST  input  1  asynchronous, active-high reset
START  input  1  single-cycle request to begin a measurement
GATE_LEN  input  GW  gate length in CLK cycles; sampled on the accepted START
RO_IN  input  1  divided ring-oscillator output; asynchronous to CLK
RO_EN  output  1  ring-oscillator enable
BUSY  output  1  high from accepted START until DONE is asserted
DONE  output  1  high while a valid result is held
COUNT  output  CW  held edge count
OVF  output  1  counter saturated during the last measurement

Behaviour:
- Reset (asynchronous, RST=1): state=IDLE; RO_EN=0, BUSY=0, DONE=0, COUNT=0, OVF=0; synchronizer flops=0; gate and edge counters=0.
- Synchronizer: RO_IN passes through 2 flops (s1, s2), then a history flop s3. Edge pulse e = s2 & ~s3 (combinational). Latency from an RO_IN rise to e is 2–3 CLK cycles.
- FSM states: IDLE, SETTLE, MEASURE, HOLD.
- IDLE:
  - START=1 → SETTLE; latch GATE_LEN; clear COUNT, OVF and DONE; BUSY=1; RO_EN=1; settle counter=0.
- SETTLE:
  - Settle counter increments each cycle.
  - After SETTLE cycles in SETTLE:
    - latched gate = 0 → HOLD directly, with COUNT=0.
    - otherwise → MEASURE, gate counter = latched gate.
- MEASURE:
  - Each cycle: if e=1, the edge counter increments, saturating at 2^CW-1. A carry attempt at all-ones sets OVF=1.
  - The gate counter decrements every cycle. The cycle in which it is 1 is the last counted cycle, so exactly GATE_LEN cycles are counted. Next state → HOLD.
  - Edges seen during SETTLE are never counted.
- HOLD:
  - RO_EN=0, BUSY=0, DONE=1; COUNT is frozen.
  - START=1 behaves as in IDLE (new measurement; DONE drops the next cycle).
- START while BUSY=1 is ignored; no queuing.
- GATE_LEN changes after acceptance have no effect.
- RST mid-measurement aborts immediately to reset values; RO_EN falls asynchronously.
- COUNT updates only on entry to HOLD. The edge counter is internal and is copied to COUNT on the MEASURE→HOLD transition, so COUNT is stable whenever DONE=1.
- Edge counter width is exactly CW; no wrap-around is ever visible (saturating).

Optional Feature:
SERIAL_READOUT_EN
- Defined: adds ports SHIFT (input 1) and SO (output 1). While DONE=1 and SHIFT=1, the held COUNT shifts right one bit per CLK and SO = COUNT[0] before the shift. Zeros fill the MSB. After CW shifts, COUNT=0 and DONE stays 1. SHIFT is ignored when DONE=0. SO resets to 0.
- Undefined: no SHIFT/SO ports; COUNT is only readable in parallel.

Test Plan:
- Reset: assert RST mid-MEASURE with RO_IN toggling → same cycle RO_EN=0, BUSY=0, DONE=0, COUNT=0, OVF=0; after release the FSM stays IDLE.
- Nominal: SETTLE=8, GATE_LEN=80, RO_IN period 8 CLK (4 high/4 low), first rise aligned so e lands 2 cycles after MEASURE entry → DONE after 1+8+80 cycles, COUNT=10, OVF=0.
- Zero gate: GATE_LEN=0, RO_IN toggling → DONE after SETTLE+1 cycles, COUNT=0, no RO_IN edges counted.
- Saturation: CW=4, GATE_LEN=100, RO_IN period 4 CLK → COUNT=15, OVF=1.
- Busy/restart: START pulsed again during MEASURE is ignored (COUNT matches the single-run value). START in HOLD with GATE_LEN=40 → DONE drops, new COUNT=5 at period 8.
- SERIAL_READOUT_EN: COUNT=0xA5C3 held, SHIFT=1 for 16 cycles → SO sequence LSB-first 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; afterwards COUNT=0.

Source files
------------

// File: rtl/as_sc_ro_freq_counter.sv
// as_sc_ro_freq_counter: ring-oscillator frequency counter.
// Enables the RO, waits SETTLE cycles, then counts synchronized rising
// edges of RO_IN over GATE_LEN CLK cycles. The saturating result is held on
// COUNT with DONE until the next START.
// Optional build macro SERIAL_READOUT_EN adds SHIFT/SO. When it is enabled,
// the held COUNT can be shifted out LSB-first.
module as_sc_ro_freq_counter #(
    parameter int CW     = 16,
    parameter int GW     = 16,
    parameter int SETTLE = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic [GW-1:0] GATE_LEN,
    input  logic          RO_IN,
`ifdef SERIAL_READOUT_EN
    input  logic          SHIFT,
    output logic          SO,
`endif
    output logic          RO_EN,
    output logic          BUSY,
    output logic          DONE,
    output logic [CW-1:0] COUNT,
    output logic          OVF
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_MEASURE, ST_HOLD} state_t;

    state_t          state_q, state_d;
    logic            s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [SW-1:0]   settle_cnt_q, settle_cnt_d;
    logic [GW-1:0]   gate_q, gate_d;
    logic [GW-1:0]   gate_cnt_q, gate_cnt_d;
    logic [CW-1:0]   edge_cnt_q, edge_cnt_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
`ifdef SERIAL_READOUT_EN
    logic            so_q, so_d;
`endif

    logic            edge_pulse;
    logic            start_acc;
    logic            settle_done;
    logic            gate_last;

    // Two-flop synchronizer plus a history flop for rising-edge detection.
    always_comb begin
        s1_d = RO_IN;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    assign edge_pulse  = s2_q & ~s3_q;
    assign start_acc   = START && (state_q == ST_IDLE || state_q == ST_HOLD);
    assign settle_done = (settle_cnt_q == SW'(SETTLE - 1));
    assign gate_last   = (gate_cnt_q == GW'(1));

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic. START is honoured only when not busy.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (START) state_d = ST_SETTLE;
            ST_SETTLE:  if (settle_done) state_d = (gate_q == '0) ? ST_HOLD : ST_MEASURE;
            ST_MEASURE: if (gate_last) state_d = ST_HOLD;
            ST_HOLD:    if (START) state_d = ST_SETTLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from state, so RO_EN drops as soon as RST asserts.
    always_comb begin
        RO_EN = 1'b0;
        BUSY  = 1'b0;
        DONE  = 1'b0;
        case (state_q)
            ST_SETTLE, ST_MEASURE: begin
                RO_EN = 1'b1;
                BUSY  = 1'b1;
            end
            ST_HOLD: DONE = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state: settle/gate counting, saturating edge count, result hold.
    always_comb begin
        settle_cnt_d = settle_cnt_q;
        gate_d       = gate_q;
        gate_cnt_d   = gate_cnt_q;
        edge_cnt_d   = edge_cnt_q;
        count_d      = count_q;
        ovf_d        = ovf_q;
`ifdef SERIAL_READOUT_EN
        so_d         = so_q;
`endif
        if (start_acc) begin
            gate_d       = GATE_LEN;
            settle_cnt_d = '0;
            edge_cnt_d   = '0;
            count_d      = '0;
            ovf_d        = 1'b0;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    settle_cnt_d = settle_cnt_q + SW'(1);
                    if (settle_done) gate_cnt_d = gate_q;
                end
                ST_MEASURE: begin
                    gate_cnt_d = gate_cnt_q - GW'(1);
                    if (edge_pulse) begin
                        if (&edge_cnt_q) ovf_d = 1'b1;
                        else             edge_cnt_d = edge_cnt_q + CW'(1);
                    end
                    // Result includes any edge seen in this final gate cycle.
                    if (gate_last) count_d = edge_cnt_d;
                end
`ifdef SERIAL_READOUT_EN
                ST_HOLD: begin
                    if (SHIFT) begin
                        so_d    = count_q[0];
                        count_d = count_q >> 1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Datapath and synchronizer registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            settle_cnt_q <= '0;
            gate_q       <= '0;
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
`ifdef SERIAL_READOUT_EN
            so_q         <= 1'b0;
`endif
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            settle_cnt_q <= settle_cnt_d;
            gate_q       <= gate_d;
            gate_cnt_q   <= gate_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
`ifdef SERIAL_READOUT_EN
            so_q         <= so_d;
`endif
        end
    end

    assign COUNT = count_q;
    assign OVF   = ovf_q;
`ifdef SERIAL_READOUT_EN
    assign SO    = so_q;
`endif

endmodule

// File: tb/tb_as_sc_ro_freq_counter.sv
// Bench for as_sc_ro_freq_counter: a 16-bit and a 4-bit instance share
// stimulus. The expected edge counts come from the recorded RO_IN sample
// history and the measurement window.
module tb_as_sc_ro_freq_counter;
    localparam int S   = 8;
    localparam int GW  = 16;
    localparam int CWA = 16;
    localparam int CWB = 4;

    logic          CLK = 1'b0;
    logic          RST, START, RO_IN;
    logic [GW-1:0] GATE_LEN;
    logic          ro_en_a, busy_a, done_a, ovf_a;
    logic          ro_en_b, busy_b, done_b, ovf_b;
    logic [CWA-1:0] count_a;
    logic [CWB-1:0] count_b;
`ifdef SERIAL_READOUT_EN
    logic          SHIFT, so_a, so_b;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit rec [0:49999];
    int ro_mode = 0;
    int ro_per  = 8;
    int ro_ph   = 0;

    as_sc_ro_freq_counter #(.CW(CWA), .GW(GW), .SETTLE(S)) u_dut (
        .CLK(CLK), .RST(RST), .START(START), .GATE_LEN(GATE_LEN), .RO_IN(RO_IN),
`ifdef SERIAL_READOUT_EN
        .SHIFT(SHIFT), .SO(so_a),
`endif
        .RO_EN(ro_en_a), .BUSY(busy_a), .DONE(done_a), .COUNT(count_a), .OVF(ovf_a));

    as_sc_ro_freq_counter #(.CW(CWB), .GW(GW), .SETTLE(S)) u_dut4 (
        .CLK(CLK), .RST(RST), .START(START), .GATE_LEN(GATE_LEN), .RO_IN(RO_IN),
`ifdef SERIAL_READOUT_EN
        .SHIFT(SHIFT), .SO(so_b),
`endif
        .RO_EN(ro_en_b), .BUSY(busy_b), .DONE(done_b), .COUNT(count_b), .OVF(ovf_b));

    always #5 CLK = ~CLK;

    // Record the RO_IN value seen at each rising edge; edge index = cyc.
    always @(posedge CLK) begin
        rec[cyc] <= RO_IN;
        cyc      <= cyc + 1;
    end

    // RO_IN source: quiet, periodic square wave, or random bits.
    always @(negedge CLK) begin
        case (ro_mode)
            0:       RO_IN <= 1'b0;
            1:       RO_IN <= ((cyc + ro_ph) % ro_per) < (ro_per / 2);
            default: RO_IN <= ($urandom_range(0, 1) != 0);
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // A rise first sampled at edge m becomes an edge pulse in the cycle after
    // edge m+1; it counts if that cycle is one of the g gate cycles, which follow
    // edges a+S .. a+S+g-1 (a = edge that accepted START).
    function automatic int model_cnt(input int a, input int g);
        int n = 0;
        for (int m = a + S - 1; m <= a + S + g - 2; m++)
            if (rec[m] && !rec[m-1]) n++;
        return n;
    endfunction

    // One measurement; poke pulses START during SETTLE and MEASURE (must be ignored).
    task automatic run(input int g, input bit poke, output int n);
        int a;
        logic [CWA-1:0] held;
        @(negedge CLK);
        START    = 1'b1;
        GATE_LEN = GW'(g);
        a        = cyc;
        ro_ph    = (ro_per - ((a + 9) % ro_per)) % ro_per;
        @(negedge CLK);
        START    = 1'b0;
        GATE_LEN = GW'($urandom);
        chk("busy_acc", busy_a, 1);
        chk("roen_acc", ro_en_a, 1);
        chk("done_acc", done_a, 0);
        chk("cnt_clr", count_a, 0);
        while (!done_a && cyc < a + S + g + 20) begin
            START = poke && g >= 4 && (cyc == a + 3 || cyc == a + S + 2);
            @(negedge CLK);
        end
        START = 1'b0;
        chk("done", done_a, 1);
        chk("lat", cyc - a, S + g + 1);
        chk("busy_hold", busy_a, 0);
        chk("roen_hold", ro_en_a, 0);
        chk("done4", done_b, 1);
        n = model_cnt(a, g);
        chk("cnt16", count_a, (n > 65535) ? 65535 : n);
        chk("ovf16", ovf_a, n > 65535);
        chk("cnt4", count_b, (n > 15) ? 15 : n);
        chk("ovf4", ovf_b, n > 15);
        held = count_a;
        repeat (3) @(negedge CLK);
        chk("cnt_frozen", count_a, held);
    endtask

    initial begin
        int n;
        RST = 1'b1; START = 1'b0; GATE_LEN = '0; RO_IN = 1'b0;
`ifdef SERIAL_READOUT_EN
        SHIFT = 1'b0;
`endif
        #12;
        chk("rst_roen", ro_en_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_cnt", count_a, 0);
        chk("rst_ovf", ovf_a, 0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (4) @(negedge CLK);

        // Nominal: period 8, gate 80 -> 10 edges.
        ro_mode = 1; ro_per = 8;
        run(80, 1'b0, n);
        chk("nom_cnt", count_a, 10);

`ifdef SERIAL_READOUT_EN
        begin
            logic [CWA-1:0] sh;
            sh = count_a;
            for (int i = 0; i < CWA; i++) begin
                SHIFT = 1'b1;
                @(negedge CLK);
                chk("so_bit", so_a, (sh >> i) & 1);
            end
            SHIFT = 1'b0;
            chk("shift_cnt0", count_a, 0);
            chk("shift_done", done_a, 1);
        end
`endif

        // Zero gate with toggling input.
        run(0, 1'b0, n);
        chk("zero_cnt", count_a, 0);

        // Saturation of the 4-bit instance: period 4, gate 100.
        ro_per = 4;
        run(100, 1'b0, n);
        chk("sat_ovf4", ovf_b, 1);

        // Reset while holding a non-zero result.
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("rsth_cnt", count_a, 0);
        chk("rsth_ovf4", ovf_b, 0);
        chk("rsth_done", done_a, 0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (4) @(negedge CLK);

        // Restart behaviour: START ignored while busy, then restart from HOLD.
        ro_per = 8;
        run(80, 1'b1, n);
        chk("poke_cnt", count_a, 10);
        run(40, 1'b0, n);
        chk("restart_cnt", count_a, 5);

        // Random gates and random RO_IN.
        for (int k = 0; k < 8; k++) begin
            ro_mode = ($urandom_range(0, 2) == 0) ? 1 : 2;
            ro_per  = 2 * $urandom_range(1, 6);
            run((k == 0) ? 1 : $urandom_range(0, 150), $urandom_range(0, 1) != 0, n);
        end

        // Reset mid-measurement with RO_IN toggling.
        ro_mode = 2;
        @(negedge CLK);
        START = 1'b1; GATE_LEN = GW'(200);
        @(negedge CLK);
        START = 1'b0;
        repeat (S + 20) @(negedge CLK);
        chk("mid_busy_pre", busy_a, 1);
        #2 RST = 1'b1;
        #1;
        chk("mid_roen", ro_en_a, 0);
        chk("mid_busy", busy_a, 0);
        chk("mid_done", done_a, 0);
        chk("mid_cnt", count_a, 0);
        chk("mid_ovf", ovf_a, 0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (6) @(negedge CLK);
        chk("idle_busy", busy_a, 0);
        chk("idle_done", done_a, 0);
        chk("idle_roen", ro_en_a, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
